// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with a req/ack backing-memory port.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
`timescale 1ns/1ps
module dcache_dm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              word,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int WB    = $clog2(WORDS);
  localparam int BW    = (WB == 0) ? 1 : WB;
  localparam int IB    = $clog2(LINES);
  localparam int OFF_W = WB + 2;
  localparam int TAG_W = ADDR_W - OFF_W - IB;

  typedef enum logic [1:0] {IDLE, EVICT, REFILL} stateT;

  stateT             state;
  logic [BW-1:0]     beat;
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [DATA_W-1:0] dataArr [LINES][WORDS];
  logic [TAG_W-1:0]  tagArr  [LINES];

  logic [IB-1:0]     index;
  logic [TAG_W-1:0]  reqTag;
  logic [BW-1:0]     wordSel;
  logic [1:0]        lane;
  logic              isReq;
  logic              hit;
  logic              lastBeat;
  logic [DATA_W-1:0] lineWord;
  logic [7:0]        laneByte;
  logic [DATA_W-1:0] merged;
  logic [ADDR_W-1:0] victimBase;
  logic [ADDR_W-1:0] refillBase;
  logic [ADDR_W-1:0] beatOff;
  logic              dataWe;
  logic [BW-1:0]     dataWord;
  logic [DATA_W-1:0] dataVal;
  logic              tagWe;

  assign index  = address[OFF_W +: IB];
  assign reqTag = address[ADDR_W-1 -: TAG_W];
  assign lane   = address[1:0];

  generate
    if (WB == 0) begin : gSingleWord
      assign wordSel = '0;
    end else begin : gMultiWord
      assign wordSel = address[WB+1:2];
    end
  endgenerate

  assign isReq      = memRead | memWrite;
  assign hit        = valid[index] && (tagArr[index] == reqTag);
  assign lastBeat   = (beat == BW'(WORDS - 1));
  assign victimBase = {tagArr[index], index, {OFF_W{1'b0}}};
  assign refillBase = {reqTag, index, {OFF_W{1'b0}}};
  assign beatOff    = ADDR_W'({beat, 2'b00});

  // A miss stalls in its own cycle; the whole line service keeps stall high.
  assign stall = (state != IDLE) || (isReq && !hit);

  always_comb begin
    lineWord = dataArr[index][wordSel];
    laneByte = lineWord[{lane, 3'b000} +: 8];
    merged   = lineWord;
    if (word) merged = write_data;
    else      merged[{lane, 3'b000} +: 8] = write_data[7:0];

    read_data = '0;
    if (state == IDLE && memRead && !memWrite && hit)
      read_data = word ? lineWord : {{(DATA_W-8){1'b0}}, laneByte};

    dataWe   = 1'b0;
    dataWord = wordSel;
    dataVal  = merged;
    tagWe    = 1'b0;
    if (state == IDLE && memWrite && hit) begin
      dataWe = 1'b1;
    end else if (state == REFILL && mem_req && mem_ack) begin
      dataWe   = 1'b1;
      dataWord = beat;
      dataVal  = mem_rdata;
      tagWe    = lastBeat;
    end
  end

  // Arrays carry no reset; only valid/dirty decide whether their contents matter.
  always_ff @(posedge clock) begin
    if (dataWe) dataArr[index][dataWord] <= dataVal;
    if (tagWe)  tagArr[index] <= reqTag;
  end

`ifdef CACHE_STATS_EN
  logic missPending;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      valid     <= '0;
      dirty     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef CACHE_STATS_EN
      hit_count   <= '0;
      miss_count  <= '0;
      missPending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (isReq && hit) begin
            if (memWrite) dirty[index] <= 1'b1;
`ifdef CACHE_STATS_EN
            if (missPending)            missPending <= 1'b0;
            else if (hit_count != '1)   hit_count   <= hit_count + 32'd1;
`endif
          end else if (isReq) begin
            beat    <= '0;
            mem_req <= 1'b1;
            if (valid[index] && dirty[index]) begin
              state     <= EVICT;
              mem_we    <= 1'b1;
              mem_addr  <= victimBase;
              mem_wdata <= dataArr[index][0];
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= refillBase;
            end
`ifdef CACHE_STATS_EN
            missPending <= 1'b1;
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        EVICT: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_addr  <= victimBase | beatOff;
            mem_wdata <= dataArr[index][beat];
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (lastBeat) begin
              dirty[index] <= 1'b0;
              mem_we       <= 1'b0;
              beat         <= '0;
              state        <= REFILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= refillBase | beatOff;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (lastBeat) begin
              valid[index] <= 1'b1;
              dirty[index] <= 1'b0;
              beat         <= '0;
              state        <= IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: backing-memory model checks every beat, loads check read data.
// Compile with CACHE_STATS_EN defined to also check the hit/miss counters.
`timescale 1ns/1ps
module tb_dcache_dm;

  localparam int ACKD = 2;  // memory acks in the ACKD-th cycle mem_req is seen high

  logic        clock = 1'b0;
  logic        rst;
  logic        memRead, memWrite, word;
  logic [31:0] address, write_data, read_data;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clock = ~clock;

  dcache_dm #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS(4)) dut (
    .clock(clock), .rst(rst),
    .memRead(memRead), .memWrite(memWrite), .word(word),
    .address(address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beatT;

  beatT        expBeats[$];
  logic [31:0] expRead[$];
  logic [31:0] mem [1024];
  int          passCnt  = 0;
  int          totalCnt = 0;
  int          reqCycles = 0;

  function automatic logic [31:0] memInit(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else passCnt++;
  endtask

  task automatic pushRefill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) expBeats.push_back('{1'b0, base + 32'(4*k), 32'h0});
  endtask

  // Backing memory: acks one beat at a time and checks it against the scoreboard.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req && !rst) begin
        reqCycles++;
        if (reqCycles == ACKD) begin
          mem_ack = 1'b1;
          if (expBeats.size() == 0) begin
            checkVal("beatUnexpected", mem_addr, 32'hFFFF_FFFF);
          end else begin
            beatT e;
            e = expBeats.pop_front();
            checkVal("beatAddr", mem_addr, e.addr);
            checkVal("beatWe", {31'b0, mem_we}, {31'b0, e.we});
            if (e.we) checkVal("beatData", mem_wdata, e.data);
          end
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[11:2]];
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        reqCycles = 0;
        mem_ack   = 1'b0;
      end
    end
  end

  task automatic waitDone(input string tag, input bit chkRead, input int expStall);
    int cycles;
    cycles = 0;
    @(negedge clock);
    while (stall && cycles < 500) begin
      cycles++;
      @(negedge clock);
    end
    checkVal({tag, "Stall"}, {31'b0, stall}, 32'h0);
    if (expStall >= 0) checkVal({tag, "Cycles"}, 32'(cycles), 32'(expStall));
    if (chkRead) checkVal({tag, "Data"}, read_data, expRead.pop_front());
    @(posedge clock);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic runAccess(input string tag, input bit rd, input bit wr, input bit wd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expData, input int expStall);
    @(posedge clock);
    #1;
    memRead    = rd;
    memWrite   = wr;
    word       = wd;
    address    = addr;
    write_data = wdata;
    if (rd && !wr) expRead.push_back(expData);
    waitDone(tag, rd && !wr, expStall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = memInit(32'(i * 4));
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; word = 1'b1;
    address = '0; write_data = '0;
    #12;
    checkVal("rstStall", {31'b0, stall}, 32'h0);
    checkVal("rstReq", {31'b0, mem_req}, 32'h0);
    checkVal("rstWe", {31'b0, mem_we}, 32'h0);
    checkVal("rstRdata", read_data, 32'h0);
`ifdef CACHE_STATS_EN
    checkVal("rstHits", hit_count, 32'h0);
    checkVal("rstMisses", miss_count, 32'h0);
`endif
    @(posedge clock);
    #1 rst = 1'b0;

    // Cold miss, clean victim, then hits on the refilled line.
    pushRefill(32'h40);
    runAccess("t1", 1, 0, 1, 32'h40, 32'h0, memInit(32'h40), 4*(ACKD+1));
    runAccess("t2", 1, 0, 1, 32'h44, 32'h0, memInit(32'h44), 0);
    runAccess("t3St", 0, 1, 0, 32'h41, 32'hFFFF_FFAB, 32'h0, 0);
    runAccess("t3Rd", 1, 0, 1, 32'h40, 32'h0, 32'hC0DE_AB40, 0);

    // Conflict miss on a dirty line: write-back of the whole line, then refill.
    expBeats.push_back('{1'b1, 32'h40, 32'hC0DE_AB40});
    for (int k = 1; k < 4; k++)
      expBeats.push_back('{1'b1, 32'h40 + 32'(4*k), memInit(32'h40 + 32'(4*k))});
    pushRefill(32'h440);
    runAccess("t4", 1, 0, 1, 32'h440, 32'h0, memInit(32'h440), 8*(ACKD+1));
`ifdef CACHE_STATS_EN
    checkVal("statHits", hit_count, 32'd3);
    checkVal("statMisses", miss_count, 32'd2);
`endif

    runAccess("byteRd", 1, 0, 0, 32'h443, 32'h0, 32'h0000_00C0, 0);
    pushRefill(32'h40);
    runAccess("wbBack", 1, 0, 1, 32'h40, 32'h0, 32'hC0DE_AB40, 4*(ACKD+1));
    runAccess("rwBoth", 1, 1, 1, 32'h48, 32'h1234_5678, 32'h0, 0);
    runAccess("rwRd", 1, 0, 1, 32'h4B, 32'h0, 32'h1234_5678, 0);
    runAccess("lane3St", 0, 1, 0, 32'h4F, 32'h0000_005A, 32'h0, 0);
    runAccess("lane3Rd", 1, 0, 1, 32'h4C, 32'h0, 32'h5ADE_004C, 0);

    // Reset during the second refill beat must drop mem_req at once and leave the line invalid.
    expBeats.push_back('{1'b0, 32'h8A0, 32'h0});
    @(posedge clock);
    #1;
    memRead = 1'b1; word = 1'b1; address = 32'h8A0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(mem_req && mem_addr == 32'h8A4) && n < 100);
    checkVal("t5Beat2", mem_addr, 32'h8A4);
    #2 rst = 1'b1;
    #1 checkVal("t5ReqDrop", {31'b0, mem_req}, 32'h0);
    @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    checkVal("t5Remiss", {31'b0, stall}, 32'h1);
    pushRefill(32'h8A0);
    expRead.push_back(memInit(32'h8A0));
    waitDone("t5", 1'b1, -1);

    repeat (4) @(negedge clock);
    checkVal("beatsLeft", 32'(expBeats.size()), 32'h0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
